// File: rtl/ps2_key_event_fifo.sv
// rtl/ps2_key_event_fifo.sv - PS/2 set-2 byte decoder with repeat filter feeding a FWFT event FIFO
module ps2_key_event_fifo #(
  parameter int DEPTH         = 8,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [7:0]               key_data,
  input  logic                     rd_en,
  output logic [9:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE_E0   = 2'd1,
    PRE_F0   = 2'd2,
    PRE_E0F0 = 2'd3
  } state_t;

  state_t state, state_next;

  logic          ev_valid;
  logic          ev_brk;
  logic          ev_ext;
  logic          lm_valid;
  logic [8:0]    lm_key;
  logic          key_match;
  logic          repeat_drop;
  logic          push;
  logic          do_write;
  logic          do_pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    mem [DEPTH];

  // Decoder state register; prefixes are forgotten on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Prefix tracking and event generation; nothing moves unless a byte arrives.
  always_comb begin
    state_next = state;
    ev_valid   = 1'b0;
    ev_brk     = 1'b0;
    ev_ext     = 1'b0;
    if (key_valid) begin
      case (state)
        IDLE: begin
          if (key_data == 8'hE0)      state_next = PRE_E0;
          else if (key_data == 8'hF0) state_next = PRE_F0;
          else if (key_data == 8'h00 || key_data == 8'hFF ||
                   key_data == 8'hAA || key_data == 8'hFA) state_next = IDLE;
          else                        ev_valid = 1'b1;
        end
        PRE_E0: begin
          if (key_data == 8'hF0)      state_next = PRE_E0F0;
          else if (key_data == 8'hE0) state_next = PRE_E0;
          else begin
            ev_valid   = 1'b1;
            ev_ext     = 1'b1;
            state_next = IDLE;
          end
        end
        PRE_F0: begin
          ev_valid   = 1'b1;
          ev_brk     = 1'b1;
          state_next = IDLE;
        end
        PRE_E0F0: begin
          ev_valid   = 1'b1;
          ev_brk     = 1'b1;
          ev_ext     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A held key produces repeated makes; only the first one is passed on.
  always_comb begin
    key_match   = lm_valid && ({ev_ext, key_data} == lm_key);
    repeat_drop = (FILTER_REPEAT != 0) && ev_valid && !ev_brk && key_match;
    push        = ev_valid && !repeat_drop;
    do_pop      = rd_en && !empty;
    do_write    = push && (!full || rd_en);
  end

  // Remember the most recent accepted make; its break releases it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lm_valid <= 1'b0;
      lm_key   <= 9'h000;
    end else if (FILTER_REPEAT != 0 && ev_valid) begin
      if (!ev_brk && !repeat_drop) begin
        lm_valid <= 1'b1;
        lm_key   <= {ev_ext, key_data};
      end else if (ev_brk && key_match) begin
        lm_valid <= 1'b0;
      end
    end
  end

  // Storage is not reset; rd_data is masked while empty instead.
  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr] <= {ev_brk, ev_ext, key_data};
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (push && full && !rd_en) overflow <= 1'b1;
    end
  end

  // Status flags and fall-through head of queue.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_COUNT);
    rd_data = empty ? 10'h000 : mem[rd_ptr];
  end

endmodule

// File: doc/ps2_key_event_fifo.md
PS2_KEY_EVENT_FIFO -- requirements
Module: ps2_key_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter FILTER_REPEAT, default 1, when 1 drop typematic repeat makes of a key already held.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe, key_data is a new PS/2 byte from the keyboard interface.
REQ-006 SHALL have port key_data  input  8  raw PS/2 set-2 byte.
REQ-007 SHALL have port rd_en  input  1  processor pop request.
REQ-008 SHALL have port rd_data  output  10  head event {brk, ext, code[7:0]}; valid when empty=0.
REQ-009 SHALL have port empty  output  1  FIFO holds no events.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH events.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  occupancy.
REQ-012 SHALL have port overflow  output  1  sticky, an event was dropped because the FIFO was full.

Function
REQ-013 SHALL decode with a 4-state FSM: IDLE, PRE_E0, PRE_F0, PRE_E0F0; decoder state changes only on cycles with key_valid=1.
REQ-014 In IDLE: 0xE0 -> PRE_E0; 0xF0 -> PRE_F0; 0x00, 0xFF, 0xAA, 0xFA ignored, stay in IDLE; any other byte -> event {0,0,byte}, stay in IDLE.
REQ-015 In PRE_E0: 0xF0 -> PRE_E0F0; 0xE0 -> stay in PRE_E0; other byte -> event {0,1,byte}, -> IDLE.
REQ-016 In PRE_F0: any byte -> event {1,0,byte}, -> IDLE.
REQ-017 In PRE_E0F0: any byte -> event {1,1,byte}, -> IDLE.
REQ-018 With FILTER_REPEAT=1, SHALL keep a last_make register {valid, ext, code}.
REQ-019 With FILTER_REPEAT=1, a make event equal to a valid last_make SHALL be discarded.
REQ-020 With FILTER_REPEAT=1, a kept make event SHALL load last_make.
REQ-021 With FILTER_REPEAT=1, a break event whose {ext, code} matches last_make SHALL clear last_make.valid.
REQ-022 With FILTER_REPEAT=1, break events SHALL always be enqueued, whether or not they match last_make.
REQ-023 An event SHALL be written into the FIFO on the same rising edge that samples the completing byte.
REQ-024 empty, count and rd_data SHALL reflect a new event in the next cycle; decode-to-visible latency is 1 cycle.
REQ-025 The FIFO SHALL be first-word-fall-through: rd_data shows the oldest entry combinationally from the registered storage and read pointer.
REQ-026 rd_en=1 with empty=0 SHALL advance the read pointer at that edge.
REQ-027 rd_en=1 with empty=1 SHALL be ignored.
REQ-028 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-029 count SHALL equal writes minus pops, saturating neither above DEPTH nor below 0.
REQ-030 An event arriving while full=1 and rd_en=0 SHALL be dropped.
REQ-031 A dropped event SHALL set overflow; overflow SHALL clear only on reset.
REQ-032 An event arriving while full=1 and rd_en=1 SHALL be accepted; count stays DEPTH and overflow is not set.
REQ-033 A push while empty=1 with rd_en=1 SHALL accept the push, ignore the pop, and leave count at 1 next cycle.
REQ-034 A simultaneous push and pop while neither full nor empty SHALL leave count unchanged.
REQ-035 full SHALL equal (count==DEPTH); empty SHALL equal (count==0).

Reset
REQ-036 reset=1 SHALL immediately, without a clock, force decoder FSM to IDLE.
REQ-037 reset=1 SHALL immediately clear last_make.valid, both pointers, count and overflow.
REQ-038 During reset, outputs SHALL be empty=1, full=0, count=0, overflow=0, rd_data=10'h000.
REQ-039 Reset asserted mid-prefix (e.g. after 0xF0) SHALL discard the prefix; the next byte after release decodes from IDLE.
REQ-040 Storage contents need not be cleared; rd_data SHALL be forced to 0 while empty=1.

Verification
REQ-041 Bytes 0x1C -> event {0,0,0x1C}; empty falls 1 cycle after the strobe; rd_data=0x01C.
REQ-042 Bytes E0 F0 75 -> single event 0x375; bytes F0 1C -> event 0x21C.
REQ-043 FILTER_REPEAT=1: bytes 1C 1C 1C F0 1C 1C -> exactly 3 events, 0x01C, 0x21C, 0x01C.
REQ-044 DEPTH=8: push 9 distinct makes with no pop -> full=1, count=8, overflow=1; pops return the first 8 in order, then empty=1.
REQ-045 DEPTH=8 full: a push coincident with rd_en -> count stays 8, overflow stays 0, new event is the last out.
REQ-046 Bytes E0 F0, then reset pulse, then 0x75 -> event 0x075; overflow=0, count=1.
